// File: rtl/fixed_to_float_sp.sv
`default_nettype none
// ============================================================================
// Module      : fixed_to_float_sp
// Description : Converts a 32-bit two's-complement fixed-point word with
//               P_FRAC_BITS fractional bits into an IEEE-754 single-precision
//               float. Streaming, one word per cycle, no backpressure.
//               The path is an input capture register followed by three stages:
//                 stage 1 - sign and unsigned magnitude
//                 stage 2 - leading-one detection and left normalisation
//                 stage 3 - round or truncate, then pack the result
//               Configuration macro FIXED_TO_FLOAT_ROUND_EN:
//                 defined   -> round to nearest, ties to even
//                 undefined -> truncate toward zero; no rounding logic built
//               o_INEXACT flags discarded nonzero bits in either mode.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_to_float_sp #(
    parameter int P_FRAC_BITS = 0
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic        i_VALID,
    input  logic [31:0] i_FIXED_WORD,
    output logic        o_VALID,
    output logic [31:0] o_FLOAT_RESULT,
    output logic        o_INEXACT
);

    // Exponent arithmetic stays within 8 bits: 127 + (0..31) - (0..31)
    // spans 96..158, and a rounding carry can only occur for p <= 30.
    localparam logic [7:0] c_EXP_BIAS  = 8'd127;
    localparam logic [7:0] c_FRAC_BITS = 8'(P_FRAC_BITS);

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic        r_in_valid;
    logic [31:0] r_in_word;

    // Register the incoming word when it is offered
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_in_valid <= 1'b0;
            r_in_word  <= 32'd0;
        end else begin
            r_in_valid <= i_VALID;
            if (i_VALID) begin
                r_in_word <= i_FIXED_WORD;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: sign and magnitude
    // ------------------------------------------------------------------
    logic [31:0] w_s1_mag;
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [31:0] r_s1_mag;

    // Negating 0x80000000 in 32 bits yields 0x80000000, which is exactly
    // the correct unsigned magnitude, so no extra width is needed.
    assign w_s1_mag = r_in_word[31] ? (~r_in_word + 32'd1) : r_in_word;

    // Capture sign and unsigned magnitude
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= 32'd0;
        end else begin
            r_s1_valid <= r_in_valid;
            if (r_in_valid) begin
                r_s1_sign <= r_in_word[31];
                r_s1_mag  <= w_s1_mag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: leading-one detection and normalisation
    // ------------------------------------------------------------------
    logic [4:0]  w_s2_pos;
    logic [4:0]  w_s2_shamt;
    logic [30:0] w_s2_norm;
    logic        w_s2_zero;

    logic        r_s2_valid;
    logic        r_s2_sign;
    logic        r_s2_zero;
    logic [4:0]  r_s2_pos;
    logic [30:0] r_s2_norm;

    // Highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        w_s2_pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_s1_mag[i]) begin
                w_s2_pos = 5'(i);
            end
        end
    end

    assign w_s2_zero  = (r_s1_mag == 32'd0);
    assign w_s2_shamt = 5'd31 - w_s2_pos;
    // After the shift the leading one sits at bit 31; it is implicit in the
    // float encoding, so only the 31 bits beneath it are kept.
    assign w_s2_norm  = 31'(r_s1_mag << w_s2_shamt);

    // Capture the normalised magnitude and its leading-one position
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b1;
            r_s2_pos   <= 5'd0;
            r_s2_norm  <= 31'd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_zero <= w_s2_zero;
                r_s2_pos  <= w_s2_pos;
                r_s2_norm <= w_s2_norm;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round or truncate, then pack
    // ------------------------------------------------------------------
    // r_s2_norm[30:8] is the 23-bit fraction; r_s2_norm[7:0] is discarded.
    logic [7:0]  w_s3_exp_base;
    logic [7:0]  w_s3_exp;
    logic [22:0] w_s3_frac;
    logic        w_s3_inexact;
    logic [31:0] w_s3_result;

    assign w_s3_exp_base = c_EXP_BIAS + {3'd0, r_s2_pos} - c_FRAC_BITS;
    assign w_s3_inexact  = |r_s2_norm[7:0];

`ifdef FIXED_TO_FLOAT_ROUND_EN
    logic        w_s3_guard;
    logic        w_s3_sticky;
    logic        w_s3_round_up;
    logic [23:0] w_s3_frac_inc;
    logic        w_s3_carry;

    // Round half to even: bump on guard when sticky is set or the kept
    // LSB is odd. A carry out of the fraction means the significand
    // overflowed to 2.0, so the exponent steps up and the fraction is zero.
    assign w_s3_guard    = r_s2_norm[7];
    assign w_s3_sticky   = |r_s2_norm[6:0];
    assign w_s3_round_up = w_s3_guard & (w_s3_sticky | r_s2_norm[8]);
    assign w_s3_frac_inc = {1'b0, r_s2_norm[30:8]} + {23'd0, w_s3_round_up};
    assign w_s3_carry    = w_s3_frac_inc[23];
    assign w_s3_frac     = w_s3_carry ? 23'd0 : w_s3_frac_inc[22:0];
    assign w_s3_exp      = w_s3_exp_base + {7'd0, w_s3_carry};
`else
    // Truncation toward zero in magnitude: simply drop the low bits
    assign w_s3_frac = r_s2_norm[30:8];
    assign w_s3_exp  = w_s3_exp_base;
`endif

    // Zero has no leading one; force +0.0 rather than packing garbage
    assign w_s3_result = r_s2_zero ? 32'd0 : {r_s2_sign, w_s3_exp, w_s3_frac};

    // Registered outputs; data holds its last value when no word arrives
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_VALID        <= 1'b0;
            o_FLOAT_RESULT <= 32'd0;
            o_INEXACT      <= 1'b0;
        end else begin
            o_VALID <= r_s2_valid;
            if (r_s2_valid) begin
                o_FLOAT_RESULT <= w_s3_result;
                o_INEXACT      <= r_s2_zero ? 1'b0 : w_s3_inexact;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_to_float_sp.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_to_float_sp
// Description : Self-checking bench for fixed_to_float_sp. Two instances
//               (P_FRAC_BITS = 0 and 16) share one input stream; every output
//               cycle is compared against an arithmetic reference model, and
//               directed words also carry hand-derived expected constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_to_float_sp;

    localparam int c_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vin = 1'b0;
    logic [31:0] win = 32'd0;

    logic        v0, v16, x0, x16;
    logic [31:0] f0, f16;

    always #5 clk = ~clk;

    fixed_to_float_sp #(.P_FRAC_BITS(0)) u_dut0 (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_VALID        (vin),
        .i_FIXED_WORD   (win),
        .o_VALID        (v0),
        .o_FLOAT_RESULT (f0),
        .o_INEXACT      (x0)
    );

    fixed_to_float_sp #(.P_FRAC_BITS(16)) u_dut16 (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_VALID        (vin),
        .i_FIXED_WORD   (win),
        .o_VALID        (v16),
        .o_FLOAT_RESULT (f16),
        .o_INEXACT      (x16)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: value = signed word / 2^f. Find the power of two of the
    // magnitude, keep 24 significant bits, and round on the remainder.
    // Returns {inexact, float}.
    function automatic logic [32:0] ref_model(input logic [31:0] w, input int f);
        longint v, mag, sig, rem, half;
        int     p, sh, e;
        logic   s;
        v = longint'($signed(w));
        if (v == 0) return 33'd0;
        s   = (v < 0);
        mag = s ? -v : v;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        rem = 0;
        if (p <= 23) begin
            sig = mag << (23 - p);
        end else begin
            sh  = p - 23;
            sig = mag >> sh;
            rem = mag - (sig << sh);
`ifdef FIXED_TO_FLOAT_ROUND_EN
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
            if (sig == (longint'(1) << 24)) begin
                sig = sig >> 1;
                p++;
            end
`endif
        end
        e = 127 + p - f;
        return {(rem != 0), s, e[7:0], sig[22:0]};
    endfunction

    // Directed expectations attached to the word currently being driven
    logic        dir_h0 = 1'b0, dir_h16 = 1'b0;
    logic [32:0] dir_c0 = '0, dir_c16 = '0;

    // What each sampling edge captured
    logic        samp_v   [c_DEPTH];
    logic [31:0] samp_w   [c_DEPTH];
    logic        samp_h0  [c_DEPTH];
    logic        samp_h16 [c_DEPTH];
    logic [32:0] samp_c0  [c_DEPTH];
    logic [32:0] samp_c16 [c_DEPTH];

    int          cyc = 0;
    logic [31:0] last_f0 = '0, last_f16 = '0;
    logic        last_x0 = 1'b0, last_x16 = 1'b0;

    initial begin
        for (int i = 0; i < c_DEPTH; i++) begin
            samp_v[i] = 1'b0;
            samp_h0[i] = 1'b0;
            samp_h16[i] = 1'b0;
        end
    end

    // Reset discards everything in flight and returns outputs to zero
    always @(negedge rst_n) begin
        for (int i = 0; i < c_DEPTH; i++) samp_v[i] = 1'b0;
        last_f0 = '0; last_f16 = '0; last_x0 = 1'b0; last_x16 = 1'b0;
    end

    // Record each sample, then check outputs one unit after the edge:
    // a word sampled at edge k is due right after edge k+3.
    always @(posedge clk) begin
        logic        ev;
        logic [32:0] m0, m16;
        int          k;
        cyc++;
        if (cyc < c_DEPTH) begin
            samp_v[cyc]   = rst_n & vin;
            samp_w[cyc]   = win;
            samp_h0[cyc]  = dir_h0;
            samp_h16[cyc] = dir_h16;
            samp_c0[cyc]  = dir_c0;
            samp_c16[cyc] = dir_c16;
        end
        #1;
        if (!rst_n) begin
            check_eq("rst_valid0", 32'(v0), 32'd0);
            check_eq("rst_result0", f0, 32'd0);
            check_eq("rst_inexact16", 32'(x16), 32'd0);
            check_eq("rst_valid16", 32'(v16), 32'd0);
        end else begin
            k  = cyc - 3;
            ev = (k >= 1 && k < c_DEPTH) ? samp_v[k] : 1'b0;
            check_eq("valid0", 32'(v0), 32'(ev));
            check_eq("valid16", 32'(v16), 32'(ev));
            if (ev) begin
                m0  = ref_model(samp_w[k], 0);
                m16 = ref_model(samp_w[k], 16);
                last_f0 = m0[31:0];   last_x0 = m0[32];
                last_f16 = m16[31:0]; last_x16 = m16[32];
                if (samp_h0[k]) begin
                    check_eq("dir_result0", f0, samp_c0[k][31:0]);
                    check_eq("dir_inexact0", 32'(x0), 32'(samp_c0[k][32]));
                end
                if (samp_h16[k]) begin
                    check_eq("dir_result16", f16, samp_c16[k][31:0]);
                    check_eq("dir_inexact16", 32'(x16), 32'(samp_c16[k][32]));
                end
            end
            check_eq("result0", f0, last_f0);
            check_eq("inexact0", 32'(x0), 32'(last_x0));
            check_eq("result16", f16, last_f16);
            check_eq("inexact16", 32'(x16), 32'(last_x16));
        end
    end

    task automatic drive(input logic [31:0] w, input logic h0, input logic [32:0] c0,
                         input logic h16, input logic [32:0] c16);
        @(negedge clk);
        vin = 1'b1; win = w;
        dir_h0 = h0; dir_c0 = c0; dir_h16 = h16; dir_c16 = c16;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vin = 1'b0; win = $urandom;
            dir_h0 = 1'b0; dir_h16 = 1'b0;
        end
    endtask

    initial begin
        logic [32:0] c_max, c_tie_odd;
        logic [31:0] w;
        int          n;

`ifdef FIXED_TO_FLOAT_ROUND_EN
        c_max     = {1'b1, 32'h4F00_0000};
        c_tie_odd = {1'b1, 32'h4B80_0002};
`else
        c_max     = {1'b1, 32'h4EFF_FFFF};
        c_tie_odd = {1'b1, 32'h4B80_0001};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed words, back to back
        drive(32'h0000_0001, 1'b1, {1'b0, 32'h3F80_0000}, 1'b0, '0);
        drive(32'hFFFF_FFFF, 1'b1, {1'b0, 32'hBF80_0000}, 1'b0, '0);
        drive(32'h0000_0000, 1'b1, {1'b0, 32'h0000_0000}, 1'b1, {1'b0, 32'h0000_0000});
        drive(32'h8000_0000, 1'b1, {1'b0, 32'hCF00_0000}, 1'b0, '0);
        drive(32'h7FFF_FFFF, 1'b1, c_max, 1'b0, '0);
        drive(32'h0100_0003, 1'b1, c_tie_odd, 1'b0, '0);
        drive(32'h0100_0001, 1'b1, {1'b1, 32'h4B80_0000}, 1'b0, '0);
        drive(32'h0001_8000, 1'b0, '0, 1'b1, {1'b0, 32'h3FC0_0000});
        drive(32'hFFFF_0000, 1'b0, '0, 1'b1, {1'b0, 32'hBF80_0000});
        idle(6);

        // Randomised stream with bubbles and varied magnitudes
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       w = $urandom;
                1:       w = 32'($urandom_range(0, 255));
                2:       w = 32'd1 << $urandom_range(0, 31);
                default: w = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 1) w = -w;
            if ($urandom_range(0, 3) != 0) drive(w, 1'b0, '0, 1'b0, '0);
            else idle(1);
        end
        idle(6);

        // Reset during streaming: two words sampled, then a one-cycle reset
        drive(32'h0000_0005, 1'b0, '0, 1'b0, '0);
        drive(32'h1234_5678, 1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        win = 32'hFFFF_FFF0;
        #1;
        check_eq("async_rst_valid0", 32'(v0), 32'd0);
        check_eq("async_rst_result0", f0, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vin = 1'b0;
        n = 0;
        while (n < 8) begin
            @(posedge clk);
            #1;
            n++;
            if (v0) break;
        end
        check_eq("post_rst_latency", 32'(n), 32'd3);
        check_eq("post_rst_result0", f0, 32'hC180_0000);

        idle(6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
